// File: rtl/rs_pkg.sv
// Shared reservation-station definitions: default slot count and slot index type.
package rs_pkg;

    localparam int RS_SIZE = 4;
    localparam int RS_IDXW = $clog2(RS_SIZE) + 1;

    typedef logic [RS_IDXW-1:0] rs_idx_t;

    localparam rs_idx_t RS_IDX_NONE = '1;

endpackage

// File: rtl/find_index.sv
// Finds the highest and next-highest set bits of a free-slot vector; all-ones means absent.
module find_index
    import rs_pkg::*;
#(
    parameter int SIZE = RS_SIZE,
    parameter int IDXW = $clog2(SIZE) + 1
) (
    input  logic [SIZE-1:0] free_vec,
    output logic [IDXW-1:0] first,
    output logic [IDXW-1:0] second
);

    localparam logic [IDXW-1:0] IDX_NONE = '1;

    // NOTE: both outputs get a default before the loop so no path leaves them unassigned (no latch).
    always_comb begin
        first  = IDX_NONE;
        second = IDX_NONE;
        // Ascending scan: each hit demotes the previous best, so the last hit is the highest.
        for (int i = 0; i < SIZE; i++) begin
            if (free_vec[i]) begin
                second = first;
                first  = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/rs_slot_alloc.sv
// Dual-lane reservation-station slot allocator: busy bitmap, free counter and in-order lane steering.
// Define SLOT_FREE_BYPASS_EN to forward free_mask into the same-cycle free-slot search.
module rs_slot_alloc
    import rs_pkg::*;
#(
    parameter int SIZE = RS_SIZE,
    parameter int IDXW = $clog2(SIZE) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      alloc_req,
    output logic [1:0]      alloc_gnt,
    output logic [IDXW-1:0] alloc_idx0,
    output logic [IDXW-1:0] alloc_idx1,
    input  logic [SIZE-1:0] free_mask,
    input  logic            flush,
    output logic [SIZE-1:0] busy,
    output logic [IDXW-1:0] free_cnt,
    output logic            full,
    output logic            empty
);

    localparam logic [IDXW-1:0] IDX_NONE  = '1;
    localparam logic [IDXW-1:0] CNT_RESET = IDXW'(SIZE);

    logic [SIZE-1:0] busy_q, busy_d;
    logic [IDXW-1:0] free_cnt_q, free_cnt_d;
    logic [SIZE-1:0] search_free;
    logic [SIZE-1:0] gnt_bits;
    logic [IDXW-1:0] first, second;
    logic [1:0]      gnt;
    logic [IDXW-1:0] idx0, idx1;

    function automatic logic [IDXW-1:0] popcnt(input logic [SIZE-1:0] v);
        logic [IDXW-1:0] c;
        c = '0;
        for (int i = 0; i < SIZE; i++) c = c + IDXW'(v[i]);
        return c;
    endfunction

`ifdef SLOT_FREE_BYPASS_EN
    assign search_free = ~(busy_q & ~free_mask);
`else
    assign search_free = ~busy_q;
`endif

    find_index #(
        .SIZE (SIZE),
        .IDXW (IDXW)
    ) u_find_index (
        .free_vec (search_free),
        .first    (first),
        .second   (second)
    );

    always_comb begin
        gnt  = '0;
        idx0 = IDX_NONE;
        idx1 = IDX_NONE;
        if (!flush) begin
            if (alloc_req[0] && first != IDX_NONE) begin
                gnt[0] = 1'b1;
                idx0   = first;
            end
            // Lane 1 only follows a granted lane 0; alone it takes the best slot.
            if (alloc_req[0]) begin
                if (alloc_req[1] && gnt[0] && second != IDX_NONE) begin
                    gnt[1] = 1'b1;
                    idx1   = second;
                end
            end else if (alloc_req[1] && first != IDX_NONE) begin
                gnt[1] = 1'b1;
                idx1   = first;
            end
        end
    end

    always_comb begin
        gnt_bits = '0;
        for (int i = 0; i < SIZE; i++) begin
            if ((gnt[0] && idx0 == IDXW'(i)) || (gnt[1] && idx1 == IDXW'(i))) gnt_bits[i] = 1'b1;
        end
        if (flush) begin
            busy_d     = '0;
            free_cnt_d = CNT_RESET;
        end else begin
            // Grants are OR-ed in after the release, so a bypassed free-then-allocate stays busy.
            busy_d     = (busy_q & ~free_mask) | gnt_bits;
            free_cnt_d = free_cnt_q + popcnt(free_mask & busy_q)
                         - IDXW'(gnt[0]) - IDXW'(gnt[1]);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= '0;
            free_cnt_q <= CNT_RESET;
        end else begin
            busy_q     <= busy_d;
            free_cnt_q <= free_cnt_d;
        end
    end

    assign alloc_gnt  = gnt;
    assign alloc_idx0 = idx0;
    assign alloc_idx1 = idx1;
    assign busy       = busy_q;
    assign free_cnt   = free_cnt_q;
    assign full       = (free_cnt_q == '0);
    assign empty      = (free_cnt_q == CNT_RESET);

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (free_cnt_q == popcnt(~busy_q))
                else $error("free_cnt out of step with busy bitmap");
            assert ((gnt_bits & busy_q & ~free_mask) == '0)
                else $error("slot granted while still busy");
            assert (!(alloc_req[0] && !gnt[0] && gnt[1]))
                else $error("lane 1 granted past a denied lane 0");
            if (!flush) begin
                assert ((free_mask & ~busy_q) == '0)
                    else $warning("free_mask releases a slot that is not busy");
            end
        end
    end

endmodule

// File: tb/tb_rs_slot_alloc.sv
// Randomized bench for rs_slot_alloc against a slot-list model, plus directed literal checks.
module tb_rs_slot_alloc;

    localparam int SIZE = 4;
    localparam int IDXW = $clog2(SIZE) + 1;

    logic            clk;
    logic            rst;
    logic [1:0]      alloc_req;
    logic [1:0]      alloc_gnt;
    logic [IDXW-1:0] alloc_idx0;
    logic [IDXW-1:0] alloc_idx1;
    logic [SIZE-1:0] free_mask;
    logic            flush;
    logic [SIZE-1:0] busy;
    logic [IDXW-1:0] free_cnt;
    logic            full;
    logic            empty;

    int n_vec = 0;
    int n_err = 0;

    bit busy_m[SIZE];
    int e_g0, e_g1, e_i0, e_i1;

    rs_slot_alloc #(
        .SIZE (SIZE),
        .IDXW (IDXW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .alloc_req  (alloc_req),
        .alloc_gnt  (alloc_gnt),
        .alloc_idx0 (alloc_idx0),
        .alloc_idx1 (alloc_idx1),
        .free_mask  (free_mask),
        .flush      (flush),
        .busy       (busy),
        .free_cnt   (free_cnt),
        .full       (full),
        .empty      (empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench did not finish");
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int idx_int(input logic [IDXW-1:0] v);
        if ($isunknown(v)) return -2;
        if (v == {IDXW{1'b1}}) return -1;
        return int'(v);
    endfunction

    function automatic int vec_int(input logic [SIZE-1:0] v);
        if ($isunknown(v)) return -2;
        return int'(v);
    endfunction

    // Expected grants from the list of free slots ordered highest index first.
    task automatic model_eval();
        int q[$];
        for (int i = SIZE - 1; i >= 0; i--) begin
`ifdef SLOT_FREE_BYPASS_EN
            if (!busy_m[i] || free_mask[i]) q.push_back(i);
`else
            if (!busy_m[i]) q.push_back(i);
`endif
        end
        e_g0 = 0; e_g1 = 0; e_i0 = -1; e_i1 = -1;
        if (!flush) begin
            if (alloc_req[0] && q.size() > 0) begin
                e_g0 = 1; e_i0 = q[0];
            end
            if (alloc_req[0] && alloc_req[1]) begin
                if (e_g0 == 1 && q.size() > 1) begin
                    e_g1 = 1; e_i1 = q[1];
                end
            end else if (alloc_req[1] && q.size() > 0) begin
                e_g1 = 1; e_i1 = q[0];
            end
        end
    endtask

    function automatic int model_busy();
        int v = 0;
        for (int i = 0; i < SIZE; i++) if (busy_m[i]) v += (1 << i);
        return v;
    endfunction

    function automatic int model_free();
        int c = 0;
        for (int i = 0; i < SIZE; i++) if (!busy_m[i]) c++;
        return c;
    endfunction

    task automatic compare_all();
        int fc;
        fc = model_free();
        check("gnt",      vec_int({2'b00, alloc_gnt}), e_g1 * 2 + e_g0);
        check("idx0",     idx_int(alloc_idx0), e_i0);
        check("idx1",     idx_int(alloc_idx1), e_i1);
        check("busy",     vec_int(busy), model_busy());
        check("free_cnt", idx_int(free_cnt), fc);
        check("full",     int'(full), (fc == 0) ? 1 : 0);
        check("empty",    int'(empty), (fc == SIZE) ? 1 : 0);
    endtask

    task automatic model_step();
        if (rst || flush) begin
            for (int i = 0; i < SIZE; i++) busy_m[i] = 1'b0;
        end else begin
            for (int i = 0; i < SIZE; i++) if (free_mask[i]) busy_m[i] = 1'b0;
            if (e_g0 == 1) busy_m[e_i0] = 1'b1;
            if (e_g1 == 1) busy_m[e_i1] = 1'b1;
        end
    endtask

    task automatic cycle(input logic [1:0] req, input logic [SIZE-1:0] fm,
                         input logic fl, input logic r, input bit cmp);
        alloc_req = req;
        free_mask = fm;
        flush     = fl;
        rst       = r;
        #1;
        model_eval();
        if (cmp) compare_all();
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    initial begin
        logic [SIZE-1:0] fm;
        rst = 1'b1; alloc_req = '0; free_mask = '0; flush = 1'b0;
        @(negedge clk);

        cycle(2'b00, 4'b0000, 1'b0, 1'b1, 1'b0); tick();
        cycle(2'b00, 4'b0000, 1'b0, 1'b1, 1'b0); tick();

        cycle(2'b11, 4'b0000, 1'b0, 1'b0, 1'b1);
        check("rst_busy",     vec_int(busy), 0);
        check("rst_free_cnt", idx_int(free_cnt), 4);
        check("rst_empty",    int'(empty), 1);
        check("rst_full",     int'(full), 0);
        check("rst_gnt",      vec_int({2'b00, alloc_gnt}), 3);
        check("rst_idx0",     idx_int(alloc_idx0), 3);
        check("rst_idx1",     idx_int(alloc_idx1), 2);
        tick();

        cycle(2'b11, 4'b0000, 1'b0, 1'b0, 1'b1);
        check("fill_idx0", idx_int(alloc_idx0), 1);
        check("fill_idx1", idx_int(alloc_idx1), 0);
        tick();

        cycle(2'b11, 4'b0000, 1'b0, 1'b0, 1'b1);
        check("full_busy", vec_int(busy), 15);
        check("full_flag", int'(full), 1);
        check("full_gnt",  vec_int({2'b00, alloc_gnt}), 0);
        check("full_idx0", idx_int(alloc_idx0), -1);
        check("full_idx1", idx_int(alloc_idx1), -1);
        tick();

        cycle(2'b01, 4'b0100, 1'b0, 1'b0, 1'b1);
`ifdef SLOT_FREE_BYPASS_EN
        check("byp_gnt",  vec_int({2'b00, alloc_gnt}), 1);
        check("byp_idx0", idx_int(alloc_idx0), 2);
        tick();
`else
        check("free_gnt_same", vec_int({2'b00, alloc_gnt}), 0);
        tick();
        cycle(2'b01, 4'b0000, 1'b0, 1'b0, 1'b1);
        check("free_gnt_next", vec_int({2'b00, alloc_gnt}), 1);
        check("free_idx0_next", idx_int(alloc_idx0), 2);
        tick();
`endif
        cycle(2'b00, 4'b0000, 1'b0, 1'b0, 1'b1);
        check("refill_busy", vec_int(busy), 15);
        check("refill_cnt",  idx_int(free_cnt), 0);
        tick();

        cycle(2'b00, 4'b0001, 1'b0, 1'b0, 1'b1); tick();
        cycle(2'b11, 4'b0000, 1'b0, 1'b0, 1'b1);
        check("inord_gnt",  vec_int({2'b00, alloc_gnt}), 1);
        check("inord_idx0", idx_int(alloc_idx0), 0);
        check("inord_idx1", idx_int(alloc_idx1), -1);
        tick();
        cycle(2'b00, 4'b0001, 1'b0, 1'b0, 1'b1); tick();
        cycle(2'b10, 4'b0000, 1'b0, 1'b0, 1'b1);
        check("lane1_gnt",  vec_int({2'b00, alloc_gnt}), 2);
        check("lane1_idx1", idx_int(alloc_idx1), 0);
        check("lane1_idx0", idx_int(alloc_idx0), -1);
        tick();

        cycle(2'b11, 4'b0011, 1'b1, 1'b0, 1'b1);
        check("flush_gnt",  vec_int({2'b00, alloc_gnt}), 0);
        check("flush_idx0", idx_int(alloc_idx0), -1);
        check("flush_idx1", idx_int(alloc_idx1), -1);
        tick();
        cycle(2'b00, 4'b0000, 1'b0, 1'b0, 1'b1);
        check("flush_busy", vec_int(busy), 0);
        check("flush_cnt",  idx_int(free_cnt), 4);
        tick();

        for (int n = 0; n < 10000; n++) begin
            for (int i = 0; i < SIZE; i++) fm[i] = busy_m[i] && ($urandom_range(0, 2) == 0);
            cycle(2'($urandom), fm, ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 99) == 0), 1'b1);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
